// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and single-outstanding instruction fetcher; optional perf counters under IFU_PERF_CNT_EN
module instr_fetch_unit #(
    parameter int IW = 16,
    parameter int AW = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          imem_ack,
    output logic [IW-1:0] instr,
    output logic [3:0]    opcode,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          dec_ready,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]   fetch_count,
    output logic [15:0]   flush_count
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, addr_q, addr_d, instr_pc_q, instr_pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic req_q, req_d, valid_q, valid_d;
    logic [AW-1:0] next_pc;
    assign next_pc = branch_taken ? branch_target : pc_q;
    // next-state: a redirect always wins; an outstanding request must still be acked before refetching
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            FETCH: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                    state_d = imem_ack ? FETCH : DRAIN;
                    addr_d  = imem_ack ? branch_target : addr_q;
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 1'b1;
                    state_d    = HOLD;
                    req_d      = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken || dec_ready) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = next_pc;
                end
            end
            DRAIN: begin
                pc_d   = next_pc;
                state_d = imem_ack ? FETCH : DRAIN;
                addr_d  = imem_ack ? next_pc : addr_q;
            end
        endcase
    end
    // state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[IW-1:IW-4];
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;
    // saturating counts of delivered (not flushed) instructions and of redirects
    always_comb begin
        fetch_cnt_d = (valid_q && dec_ready && !branch_taken && fetch_cnt_q != 16'hFFFF) ? fetch_cnt_q + 16'd1 : fetch_cnt_q;
        flush_cnt_d = (branch_taken && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end
    // counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`endif
endmodule
